rom_dl_sequencer: RTL and testbench
===================================

# rom_dl_sequencer

Transmit end of the ROM download interface. Accepts the host loader's byte stream (ioctl strobes with address and data), buffers it, and replays it as paced single-cycle dl_addr/dl_data/dl_wr write strobes to the program-ROM and vector-ROM load ports. It also holds the game core in reset for the whole download and reports completion with a byte count and checksum. It sits between the framework ioctl bus and the top-level dl_* inputs.

## Interface
Parameters:
- WR_SPACING, 4: minimum clocks from one dl_wr pulse to the next. Legal range 1..15.
- ADDR_LIMIT, 'h5000: bytes with ioctl_addr >= ADDR_LIMIT are counted as dropped and never written.
- HOLD_CYCLES, 16: clocks core_hold stays high after the last dl_wr.

Ports:
- clk  in  1: system clock; all logic on the rising edge.
- rst_l  in  1: asynchronous, active-low reset.
- ioctl_download  in  1: high while the host is downloading.
- ioctl_wr  in  1: one-cycle byte strobe; valid only while ioctl_download is high.
- ioctl_addr  in  25: byte address.
- ioctl_dout  in  8: byte data.
- ioctl_wait  out  1: backpressure to the host.
- dl_addr  out  25: write address, held between strobes.
- dl_data  out  8: write data, held between strobes.
- dl_wr  out  1: one-cycle write strobe.
- core_hold  out  1: high keeps the core and the rasterizer in reset.
- dl_done  out  1: one-cycle pulse when the download completes.
- byte_count  out  16: number of bytes written via dl_wr in the current or last download.
- drop_count  out  16: number of bytes rejected by ADDR_LIMIT.
- checksum  out  16: modulo-2^16 sum of all written bytes.

## Operation
- Buffering: 4-entry FIFO of {addr[24:0], data[7:0]}.
  - Push on ioctl_wr & ioctl_download & (ioctl_addr < ADDR_LIMIT).
  - ioctl_wait = (fifo count >= 3) | (state == RELEASE).
  - A push into a full FIFO is a host protocol violation. The byte is discarded and drop_count increments.
- Pacing counter (4 bits): loads WR_SPACING-1 on each dl_wr and counts down to 0. A pop may occur only when the counter is 0.
- Pop: dl_wr=1 for one clock, and dl_addr/dl_data update in that same clock. byte_count += 1 and checksum += data, both saturating-free and wrapping at 2^16.
- FSM states:
  - IDLE: core_hold=0. On ioctl_download rising edge, go to LOAD, clear byte_count, drop_count and checksum, and set core_hold=1.
  - LOAD: accept pushes and pop when allowed. When ioctl_download falls, go to DRAIN.
  - DRAIN: no pushes; pop until the FIFO is empty, then go to RELEASE and load the hold counter with HOLD_CYCLES-1.
  - RELEASE: hold counter decrements to 0. On 0, pulse dl_done, clear core_hold and go to IDLE.
- ioctl_download rising while in DRAIN or RELEASE: go to LOAD immediately. Counters clear, FIFO contents are kept and still written, and core_hold stays 1 with no glitch.
- Simultaneous push and pop in one clock: count is unchanged, and both the push and the pop take effect.

## Timing
- Reset values:
  - ioctl_wait=0, dl_addr=0, dl_data=0, dl_wr=0, core_hold=0, dl_done=0.
  - byte_count=0, drop_count=0, checksum=0.
  - FSM=IDLE, FIFO empty, pacing counter=0.
- Reset is asynchronous and may arrive mid-download. All outputs take their reset values immediately, FIFO contents are lost, and there is no dl_done.
- Latency with an empty FIFO and pacing counter 0: ioctl_wr at cycle N gives dl_wr at cycle N+1, because registered FIFO output is followed by a registered strobe.
- Sustained throughput is one byte per WR_SPACING clocks. With WR_SPACING=1, a write is possible every clock.
- ioctl_wait is combinational from registered count and state, so it is visible in the same cycle that count reaches 3.
- core_hold rises in the clock after the ioctl_download rising edge.
- core_hold falls HOLD_CYCLES clocks after the last dl_wr, in the same cycle as dl_done.

## Test plan
- Reset, then 16 sequential bytes to addr 0..15 (data = addr+1), with WR_SPACING=4 and ioctl_wr every clock:
  - ioctl_wait asserts.
  - Exactly 16 dl_wr pulses, each 4 clocks apart, with matching addr/data.
  - byte_count=16, checksum=136.
  - dl_done occurs 16 clocks after the last write, and core_hold falls in the same cycle.
- Bytes at 'h4FFF and 'h5000 -> only 'h4FFF is written; drop_count=1.
- ioctl_download drops while 3 entries are still buffered -> 3 more dl_wr pulses occur, then RELEASE, then dl_done.
- Re-raise ioctl_download during RELEASE -> core_hold stays 1 continuously, no dl_done, counters cleared.
- Deassert rst_l during LOAD with 2 entries queued -> no further dl_wr; all outputs are 0 in the same cycle.
- Host ignores ioctl_wait and pushes 6 bytes back-to-back with WR_SPACING=15 -> drop_count=1, and the remaining 5 bytes are written in order.

Source files
------------

// File: rtl/rom_dl_sequencer.sv
`timescale 1ns/1ps
// rom_dl_sequencer: buffers the host ioctl byte stream in a 4-entry FIFO and
// replays it as paced dl_wr strobes to the ROM load ports, holding the core
// in reset for the whole download and reporting a byte count and checksum.
module rom_dl_sequencer #(
   parameter int unsigned WR_SPACING  = 4,
   parameter logic [24:0] ADDR_LIMIT  = 25'h5000,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [24:0] dl_addr,
   output logic [7:0]  dl_data,
   output logic        dl_wr,
   output logic        core_hold,
   output logic        dl_done,
   output logic [15:0] byte_count,
   output logic [15:0] drop_count,
   output logic [15:0] checksum
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LOAD    = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   localparam logic [3:0]  PACE_LOAD = 4'(WR_SPACING - 1);
   localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

   logic [1:0]  state;
   logic        dl_q;
   logic [3:0]  pace_cnt;
   logic [15:0] hold_cnt;

   logic [24:0] fifo_addr [4];
   logic [7:0]  fifo_data [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;

   logic        dl_rise;
   logic        in_range;
   logic        push_req;
   logic        push;
   logic        pop;
   logic        drop_inc;
   logic        drain_empty;
   logic [7:0]  pop_data;

   // push/pop decisions and backpressure, all from registered state
   always_comb begin
      dl_rise     = ioctl_download & ~dl_q;
      in_range    = ioctl_addr < ADDR_LIMIT;
      push_req    = ioctl_wr & ioctl_download & in_range;
      pop         = (count != 3'd0) && (pace_cnt == 4'd0);
      // a full FIFO still accepts a byte when an entry leaves in the same clock
      push        = push_req & ((count != 3'd4) | pop);
      drop_inc    = (ioctl_wr & ioctl_download & ~in_range) | (push_req & ~push);
      // FIFO is empty after this clock (no pushes happen while draining)
      drain_empty = (count == 3'd0) || ((count == 3'd1) && pop && !push);
      pop_data    = fifo_data[rd_ptr];
      ioctl_wait  = (count >= 3'd3) | (state == ST_RELEASE);
   end

   // FIFO storage; contents are don't-care once the pointers reset
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= ioctl_addr;
         fifo_data[wr_ptr] <= ioctl_dout;
      end
   end

   // FIFO pointers, occupancy and download edge detect
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dl_q   <= 1'b0;
      end else begin
         dl_q <= ioctl_download;
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // registered write port and strobe pacing
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         dl_addr  <= '0;
         dl_data  <= '0;
         dl_wr    <= 1'b0;
         pace_cnt <= '0;
      end else begin
         dl_wr <= pop;
         if (pop) begin
            dl_addr  <= fifo_addr[rd_ptr];
            dl_data  <= pop_data;
            pace_cnt <= PACE_LOAD;
         end else if (pace_cnt != 4'd0) begin
            pace_cnt <= pace_cnt - 4'd1;
         end
      end
   end

   // statistics; a new download clears them but bytes moving in that clock still count
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         byte_count <= '0;
         drop_count <= '0;
         checksum   <= '0;
      end else begin
         byte_count <= (dl_rise ? 16'd0 : byte_count) + {15'd0, pop};
         drop_count <= (dl_rise ? 16'd0 : drop_count) + {15'd0, drop_inc};
         checksum   <= (dl_rise ? 16'd0 : checksum) + (pop ? {8'd0, pop_data} : 16'd0);
      end
   end

   // download sequencing, core hold and completion pulse
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state     <= ST_IDLE;
         hold_cnt  <= '0;
         core_hold <= 1'b0;
         dl_done   <= 1'b0;
      end else begin
         dl_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (dl_rise) begin
                  state     <= ST_LOAD;
                  core_hold <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (!ioctl_download) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (dl_rise) begin
                  state <= ST_LOAD;
               end else if (drain_empty) begin
                  // entering on the final pop keeps the hold exactly HOLD_CYCLES long
                  state    <= ST_RELEASE;
                  hold_cnt <= HOLD_LOAD;
               end
            end
            default: begin
               if (dl_rise) begin
                  state <= ST_LOAD;
               end else if (hold_cnt == 16'd0) begin
                  state     <= ST_IDLE;
                  core_hold <= 1'b0;
                  dl_done   <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
`timescale 1ns/1ps
// tb_rom_dl_sequencer: directed checks of the ROM download sequencer, with a
// table of short downloads plus hand-written multi-cycle sequences.
module tb_rom_dl_sequencer;

   logic        clk;
   logic        rst_l;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;

   logic        ioctl_wait, dl_wr, core_hold, dl_done;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic [15:0] byte_count, drop_count, checksum;

   logic        ioctl_wait_b, dl_wr_b, core_hold_b, dl_done_b;
   logic [24:0] dl_addr_b;
   logic [7:0]  dl_data_b;
   logic [15:0] byte_count_b, drop_count_b, checksum_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   rom_dl_sequencer #(.WR_SPACING(4), .ADDR_LIMIT(25'h5000), .HOLD_CYCLES(16)) dut (
      .clk(clk), .rst_l(rst_l), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr), .core_hold(core_hold),
      .dl_done(dl_done), .byte_count(byte_count), .drop_count(drop_count), .checksum(checksum)
   );

   rom_dl_sequencer #(.WR_SPACING(15), .ADDR_LIMIT(25'h5000), .HOLD_CYCLES(16)) dut_b (
      .clk(clk), .rst_l(rst_l), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait_b),
      .dl_addr(dl_addr_b), .dl_data(dl_data_b), .dl_wr(dl_wr_b), .core_hold(core_hold_b),
      .dl_done(dl_done_b), .byte_count(byte_count_b), .drop_count(drop_count_b), .checksum(checksum_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // write / done / hold-fall monitors sampled on the falling edge
   logic [24:0] wa_addr [128];
   logic [7:0]  wa_data [128];
   int          wa_cyc  [128];
   int          wr_cnt_a = 0;
   logic [24:0] wb_addr [128];
   logic [7:0]  wb_data [128];
   int          wb_cyc  [128];
   int          wr_cnt_b = 0;
   int          done_cnt_a = 0, done_cyc_a = 0;
   int          done_cnt_b = 0;
   int          fall_cnt_a = 0, fall_cyc_a = 0;
   logic        hold_prev = 1'b0;

   always @(negedge clk) begin
      if (dl_wr) begin
         if (wr_cnt_a < 128) begin
            wa_addr[wr_cnt_a] = dl_addr;
            wa_data[wr_cnt_a] = dl_data;
            wa_cyc[wr_cnt_a]  = cyc;
         end
         wr_cnt_a = wr_cnt_a + 1;
      end
      if (dl_wr_b) begin
         if (wr_cnt_b < 128) begin
            wb_addr[wr_cnt_b] = dl_addr_b;
            wb_data[wr_cnt_b] = dl_data_b;
            wb_cyc[wr_cnt_b]  = cyc;
         end
         wr_cnt_b = wr_cnt_b + 1;
      end
      if (dl_done) begin
         done_cnt_a = done_cnt_a + 1;
         done_cyc_a = cyc;
      end
      if (dl_done_b) done_cnt_b = done_cnt_b + 1;
      if (hold_prev && !core_hold) begin
         fall_cnt_a = fall_cnt_a + 1;
         fall_cyc_a = cyc;
      end
      hold_prev = core_hold;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit use_b, input int bound, input string name);
      int start;
      start = use_b ? done_cnt_b : done_cnt_a;
      for (int i = 0; i < bound; i++) begin
         if ((use_b ? done_cnt_b : done_cnt_a) != start) break;
         @(posedge clk);
      end
      #1;
      chk(name, ((use_b ? done_cnt_b : done_cnt_a) != start), 32'd1);
   endtask

   task automatic do_reset();
      rst_l = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      tick();
      tick();
      rst_l = 1'b1;
      tick();
   endtask

   typedef struct {
      logic [24:0] a0;
      logic [7:0]  d0;
      logic [24:0] a1;
      logic [7:0]  d1;
      int          exp_bytes;
      logic [15:0] exp_drop;
      logic [15:0] exp_sum;
      logic [24:0] exp_addr;
      logic [7:0]  exp_data;
      bit          lat_chk;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int base, sent, first_push, guard, snap, dsnap, fsnap;
      bit wait_seen;

      vecs[0] = '{25'h0010, 8'hAA, 25'h0011, 8'h55, 2, 16'd0, 16'h00FF, 25'h0011, 8'h55, 1'b1};
      vecs[1] = '{25'h4FFF, 8'h12, 25'h5000, 8'h34, 1, 16'd1, 16'h0012, 25'h4FFF, 8'h12, 1'b1};
      vecs[2] = '{25'h5000, 8'h01, 25'h1FFFFFF, 8'hFF, 0, 16'd2, 16'h0000, 25'h4FFF, 8'h12, 1'b0};
      vecs[3] = '{25'h0000, 8'hFF, 25'h4FFE, 8'hFF, 2, 16'd0, 16'h01FE, 25'h4FFE, 8'hFF, 1'b1};

      // reset state
      rst_l = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      tick();
      tick();
      chk("rst_wait", {31'd0, ioctl_wait}, 0);
      chk("rst_dl_addr", {7'd0, dl_addr}, 0);
      chk("rst_dl_wr", {31'd0, dl_wr}, 0);
      chk("rst_core_hold", {31'd0, core_hold}, 0);
      chk("rst_counts", {byte_count, checksum}, 0);
      rst_l = 1'b1;
      tick();

      // 16 sequential bytes, host honours ioctl_wait
      base = wr_cnt_a;
      ioctl_download = 1'b1;
      tick();
      chk("hold_rise", {31'd0, core_hold}, 1);
      sent = 0;
      wait_seen = 1'b0;
      first_push = 0;
      guard = 0;
      while (sent < 16 && guard < 300) begin
         guard++;
         if (!ioctl_wait) begin
            ioctl_wr = 1'b1;
            ioctl_addr = 25'(sent);
            ioctl_dout = 8'(sent + 1);
            sent++;
            tick();
            if (sent == 1) first_push = cyc;
         end else begin
            wait_seen = 1'b1;
            ioctl_wr = 1'b0;
            tick();
         end
      end
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      tick();
      wait_done(1'b0, 200, "seq16_done");
      chk("seq16_wait_seen", {31'd0, wait_seen}, 1);
      chk("seq16_writes", 32'(wr_cnt_a - base), 16);
      for (int i = 0; i < 16; i++) begin
         chk("seq16_addr", {7'd0, wa_addr[base + i]}, 32'(i));
         chk("seq16_data", {24'd0, wa_data[base + i]}, 32'(i + 1));
         if (i > 0) chk("seq16_gap", 32'(wa_cyc[base + i] - wa_cyc[base + i - 1]), 4);
      end
      chk("seq16_latency", 32'(wa_cyc[base] - first_push), 1);
      chk("seq16_byte_count", {16'd0, byte_count}, 16);
      chk("seq16_checksum", {16'd0, checksum}, 136);
      chk("seq16_drop_count", {16'd0, drop_count}, 0);
      chk("seq16_done_delay", 32'(done_cyc_a - wa_cyc[base + 15]), 16);
      chk("seq16_hold_fall", 32'(fall_cyc_a), 32'(done_cyc_a));
      chk("seq16_hold_low", {31'd0, core_hold}, 0);

      // table of two-byte downloads
      for (int v = 0; v < 4; v++) begin
         base = wr_cnt_a;
         ioctl_download = 1'b1;
         tick();
         ioctl_wr = 1'b1;
         ioctl_addr = vecs[v].a0;
         ioctl_dout = vecs[v].d0;
         tick();
         first_push = cyc;
         ioctl_addr = vecs[v].a1;
         ioctl_dout = vecs[v].d1;
         tick();
         ioctl_wr = 1'b0;
         ioctl_download = 1'b0;
         tick();
         wait_done(1'b0, 100, "vec_done");
         chk("vec_writes", 32'(wr_cnt_a - base), 32'(vecs[v].exp_bytes));
         chk("vec_byte_count", {16'd0, byte_count}, 32'(vecs[v].exp_bytes));
         chk("vec_drop_count", {16'd0, drop_count}, {16'd0, vecs[v].exp_drop});
         chk("vec_checksum", {16'd0, checksum}, {16'd0, vecs[v].exp_sum});
         chk("vec_dl_addr", {7'd0, dl_addr}, {7'd0, vecs[v].exp_addr});
         chk("vec_dl_data", {24'd0, dl_data}, {24'd0, vecs[v].exp_data});
         if (vecs[v].lat_chk) chk("vec_latency", 32'(wa_cyc[base] - first_push), 1);
      end

      // download drops with 3 entries still buffered
      base = wr_cnt_a;
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         ioctl_wr = 1'b1;
         ioctl_addr = 25'h200 + 25'(i);
         ioctl_dout = 8'h30 + 8'(i);
         tick();
      end
      chk("drain_wait_at_3", {31'd0, ioctl_wait}, 1);
      chk("drain_writes_before", 32'(wr_cnt_a - base), 1);
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      tick();
      wait_done(1'b0, 200, "drain_done");
      chk("drain_writes", 32'(wr_cnt_a - base), 4);
      chk("drain_last_addr", {7'd0, wa_addr[base + 3]}, 32'h203);
      chk("drain_byte_count", {16'd0, byte_count}, 4);
      chk("drain_checksum", {16'd0, checksum}, 32'h00C6);
      chk("drain_done_delay", 32'(done_cyc_a - wa_cyc[base + 3]), 16);

      // re-raise ioctl_download during RELEASE
      base = wr_cnt_a;
      ioctl_download = 1'b1;
      tick();
      ioctl_wr = 1'b1;
      ioctl_addr = 25'h300;
      ioctl_dout = 8'h77;
      tick();
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("rel_written", 32'(wr_cnt_a - base), 1);
      chk("rel_checksum_before", {16'd0, checksum}, 32'h77);
      chk("rel_wait_in_release", {31'd0, ioctl_wait}, 1);
      dsnap = done_cnt_a;
      fsnap = fall_cnt_a;
      ioctl_download = 1'b1;
      tick();
      chk("rel_hold_kept", {31'd0, core_hold}, 1);
      chk("rel_byte_count_clr", {16'd0, byte_count}, 0);
      chk("rel_checksum_clr", {16'd0, checksum}, 0);
      for (int i = 0; i < 30; i++) tick();
      chk("rel_no_done", 32'(done_cnt_a - dsnap), 0);
      chk("rel_no_hold_fall", 32'(fall_cnt_a - fsnap), 0);
      ioctl_wr = 1'b1;
      ioctl_addr = 25'h301;
      ioctl_dout = 8'h05;
      tick();
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      tick();
      wait_done(1'b0, 100, "rel_done");
      chk("rel_byte_count", {16'd0, byte_count}, 1);
      chk("rel_checksum", {16'd0, checksum}, 5);

      // asynchronous reset mid-LOAD with 2 entries queued
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         ioctl_wr = 1'b1;
         ioctl_addr = 25'h400 + 25'(i);
         ioctl_dout = 8'h41 + 8'(i);
         tick();
      end
      ioctl_wr = 1'b0;
      chk("arst_pre_hold", {31'd0, core_hold}, 1);
      chk("arst_pre_addr", {7'd0, dl_addr}, 32'h400);
      #2;
      snap = wr_cnt_a;
      dsnap = done_cnt_a;
      rst_l = 1'b0;
      #1;
      chk("arst_core_hold", {31'd0, core_hold}, 0);
      chk("arst_dl_addr", {7'd0, dl_addr}, 0);
      chk("arst_dl_data", {24'd0, dl_data}, 0);
      chk("arst_strobes", {29'd0, dl_wr, dl_done, ioctl_wait}, 0);
      chk("arst_byte_count", {16'd0, byte_count}, 0);
      chk("arst_drop_checksum", {drop_count, checksum}, 0);
      ioctl_download = 1'b0;
      tick();
      tick();
      rst_l = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      chk("arst_no_writes", 32'(wr_cnt_a - snap), 0);
      chk("arst_no_done", 32'(done_cnt_a - dsnap), 0);

      // host ignores ioctl_wait: 6 back-to-back bytes at WR_SPACING=15
      do_reset();
      base = wr_cnt_b;
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         ioctl_wr = 1'b1;
         ioctl_addr = 25'h500 + 25'(i);
         ioctl_dout = 8'h60 + 8'(i);
         tick();
      end
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      tick();
      wait_done(1'b1, 300, "ovf_done");
      chk("ovf_drop_count", {16'd0, drop_count_b}, 1);
      chk("ovf_byte_count", {16'd0, byte_count_b}, 5);
      chk("ovf_writes", 32'(wr_cnt_b - base), 5);
      chk("ovf_checksum", {16'd0, checksum_b}, 32'h01EA);
      for (int i = 0; i < 5; i++) begin
         chk("ovf_addr", {7'd0, wb_addr[base + i]}, 32'h500 + 32'(i));
         chk("ovf_data", {24'd0, wb_data[base + i]}, 32'h60 + 32'(i));
         if (i > 0) chk("ovf_gap", 32'(wb_cyc[base + i] - wb_cyc[base + i - 1]), 15);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
